// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed address/data bus sequencer: one address phase + one data phase per request.
// Optional one-entry pending request slot enabled by defining RTC_REQ_QUEUE_EN.
module rtc_bus_ctrl #(
   parameter int T_SETUP  = 2,
   parameter int T_STROBE = 4,
   parameter int T_HOLD   = 2,
   parameter int T_GAP    = 3
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       req_i,
   input  logic       wr_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic       req_ack_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rdata_o,
   output logic       cs_n_o,
   output logic       ad_n_o,
   output logic       rd_n_o,
   output logic       wr_n_o,
   output logic [7:0] ad_out_o,
   output logic       ad_oe_o,
   input  logic [7:0] ad_in_i
);

   localparam int MAXP_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
   localparam int MAXP_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
   localparam int MAXP   = (MAXP_A > MAXP_B) ? MAXP_A : MAXP_B;
   localparam int CW     = $clog2(MAXP + 1);

   typedef enum logic [3:0] {
      IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic [7:0]      addr_q, addr_d, wdata_q, wdata_d;
   logic            ack_d, busy_d;
   logic            cs_n_d, ad_n_d, rd_n_d, wr_n_d, oe_d, done_d;
   logic [7:0]      out_d;
   logic            ack_q, busy_q, done_q, cs_n_q, ad_n_q, rd_n_q, wr_n_q, oe_q;
   logic [7:0]      out_q, rdata_q;
`ifdef RTC_REQ_QUEUE_EN
   logic            pend_v_q, pend_v_d, pend_wr_q, pend_wr_d;
   logic [7:0]      pend_addr_q, pend_addr_d, pend_wdata_q, pend_wdata_d;
`endif

   // Counter holds (cycles remaining - 1) for the current timed state.
   function automatic logic [CW-1:0] reload(input state_e s);
      case (s)
         A_SETUP, D_SETUP:   return CW'(T_SETUP - 1);
         A_STROBE, D_STROBE: return CW'(T_STROBE - 1);
         A_HOLD, D_HOLD:     return CW'(T_HOLD - 1);
         GAP:                return CW'(T_GAP - 1);
         default:            return '0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ack_d   = 1'b0;
`ifdef RTC_REQ_QUEUE_EN
      pend_v_d     = pend_v_q;
      pend_wr_d    = pend_wr_q;
      pend_addr_d  = pend_addr_q;
      pend_wdata_d = pend_wdata_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef RTC_REQ_QUEUE_EN
            if (pend_v_q) begin
               state_d  = A_SETUP;
               wr_d     = pend_wr_q;
               addr_d   = pend_addr_q;
               wdata_d  = pend_wdata_q;
               pend_v_d = 1'b0;
            end else
`endif
            if (req_i) begin
               state_d = A_SETUP;
               wr_d    = wr_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               ack_d   = 1'b1;
            end
         end
         A_SETUP:  if (cnt_q == '0) state_d = A_STROBE;
         A_STROBE: if (cnt_q == '0) state_d = A_HOLD;
         A_HOLD:   if (cnt_q == '0) state_d = GAP;
         GAP:      if (cnt_q == '0) state_d = D_SETUP;
         D_SETUP:  if (cnt_q == '0) state_d = D_STROBE;
         D_STROBE: if (cnt_q == '0) state_d = D_HOLD;
         D_HOLD:   if (cnt_q == '0) state_d = DONE;
         DONE: begin
            state_d = IDLE;
`ifdef RTC_REQ_QUEUE_EN
            if (pend_v_q) begin
               state_d  = A_SETUP;
               wr_d     = pend_wr_q;
               addr_d   = pend_addr_q;
               wdata_d  = pend_wdata_q;
               pend_v_d = 1'b0;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
`ifdef RTC_REQ_QUEUE_EN
      // Slot is full whenever a launch from it is pending, so this never collides with a launch.
      if (state_q != IDLE && req_i && !pend_v_q) begin
         pend_v_d     = 1'b1;
         pend_wr_d    = wr_i;
         pend_addr_d  = addr_i;
         pend_wdata_d = wdata_i;
         ack_d        = 1'b1;
      end
`endif
      if (state_d != state_q) cnt_d = reload(state_d);
   end

   // Pin values are decoded from the next state so every output comes straight from a flop.
   always_comb begin
      cs_n_d = 1'b1;
      ad_n_d = 1'b1;
      rd_n_d = 1'b1;
      wr_n_d = 1'b1;
      oe_d   = 1'b0;
      out_d  = 8'h00;
      done_d = 1'b0;
      busy_d = (state_d != IDLE);
      case (state_d)
         A_SETUP, A_STROBE, A_HOLD: begin
            cs_n_d = 1'b0;
            ad_n_d = 1'b0;
            oe_d   = 1'b1;
            out_d  = addr_d;
            wr_n_d = (state_d != A_STROBE);
         end
         D_SETUP, D_STROBE, D_HOLD: begin
            cs_n_d = 1'b0;
            if (wr_d) begin
               oe_d   = 1'b1;
               out_d  = wdata_d;
               wr_n_d = (state_d != D_STROBE);
            end else begin
               rd_n_d = (state_d != D_STROBE);
            end
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         ad_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         out_q   <= 8'h00;
         rdata_q <= 8'h00;
`ifdef RTC_REQ_QUEUE_EN
         pend_v_q     <= 1'b0;
         pend_wr_q    <= 1'b0;
         pend_addr_q  <= 8'h00;
         pend_wdata_q <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_n_q  <= cs_n_d;
         ad_n_q  <= ad_n_d;
         rd_n_q  <= rd_n_d;
         wr_n_q  <= wr_n_d;
         oe_q    <= oe_d;
         out_q   <= out_d;
         if (state_q == D_STROBE && cnt_q == '0 && !wr_q) rdata_q <= ad_in_i;
`ifdef RTC_REQ_QUEUE_EN
         pend_v_q     <= pend_v_d;
         pend_wr_q    <= pend_wr_d;
         pend_addr_q  <= pend_addr_d;
         pend_wdata_q <= pend_wdata_d;
`endif
      end
   end

   assign req_ack_o = ack_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rdata_o   = rdata_q;
   assign cs_n_o    = cs_n_q;
   assign ad_n_o    = ad_n_q;
   assign rd_n_o    = rd_n_q;
   assign wr_n_o    = wr_n_q;
   assign ad_out_o  = out_q;
   assign ad_oe_o   = oe_q;

endmodule
